consmax_pack: RTL and testbench

- Sits directly downstream of the ConSmax element unit.
- Collects its per-element INT outputs (one per cycle, no backpressure upstream) into PACK_NUM-lane words for the score×V matmul array.
- Pads and flags the end of each attention row, and buffers packed words in a small FIFO with valid/ready output.
- Reports a sticky overflow flag when the consumer stalls too long.

---
 rtl/consmax_pack_pkg.sv | 20 ++
 rtl/consmax_pack_fifo.sv | 42 ++++
 rtl/consmax_pack.sv | 112 +++++++++++
 tb/tb_consmax_pack.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/consmax_pack_pkg.sv
// consmax_pkg: shared widths, FIFO sizing and the packed FIFO entry for consmax_pack.
// Optional macro CONSMAX_PACK_SUM_EN adds the per-row signed sum field to the entry.
package consmax_pkg;
  localparam int IDATA_BIT = 8;
  localparam int PACK_NUM = 8;
  localparam int ODATA_BIT = IDATA_BIT * PACK_NUM;
  localparam int ROW_BIT = 10;
  localparam int SUM_BIT = IDATA_BIT + ROW_BIT;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_BIT = $clog2(FIFO_DEPTH);
  localparam int CNT_BIT = $clog2(FIFO_DEPTH + 1);
  typedef struct packed {
    logic [ODATA_BIT-1:0] data;
    logic [PACK_NUM-1:0] mask;
    logic last;
`ifdef CONSMAX_PACK_SUM_EN
    logic signed [SUM_BIT-1:0] sum;
`endif
  } entry_t;
endpackage

// File: rtl/consmax_pack_fifo.sv
// consmax_pack_fifo: synchronous first-word-fall-through FIFO with registered storage.
// Ports: clk, rst (async, active-high), push_i/push_data_i write side, pop_i read side,
// data_o head entry, full_o / empty_o status. A push while full is taken only if a pop
// happens in the same cycle.
module consmax_pack_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic pop_ok, accept;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign pop_ok = pop_i && !empty_o;
  assign accept = push_i && (!full_o || pop_ok);
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) mem_q[wr_q] <= push_data_i;
      wr_q <= accept ? wr_q + PW'(1) : wr_q;
      rd_q <= pop_ok ? rd_q + PW'(1) : rd_q;
      count_q <= count_q + CW'(accept) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/consmax_pack.sv
// consmax_pack: packs per-element ConSmax outputs into PACK_NUM-lane words, pads/flags row ends,
// buffers words in a FWFT FIFO with valid/ready and flags dropped words with a sticky overflow.
// Ports: clk, rst (async, active-high); cfg_row_len (0 means 1); clr_overflow; idata/idata_valid in;
// odata/odata_mask/odata_last/odata_valid out with odata_ready; overflow.
// Macro CONSMAX_PACK_SUM_EN adds odata_sum, the signed row sum reported on the last word of a row.
module consmax_pack #(
  parameter int IDATA_BIT = consmax_pkg::IDATA_BIT,
  parameter int PACK_NUM = consmax_pkg::PACK_NUM,
  parameter int ODATA_BIT = IDATA_BIT * PACK_NUM,
  parameter int FIFO_DEPTH = consmax_pkg::FIFO_DEPTH,
  parameter int ROW_BIT = consmax_pkg::ROW_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROW_BIT-1:0]   cfg_row_len,
  input  logic                 clr_overflow,
  input  logic [IDATA_BIT-1:0] idata,
  input  logic                 idata_valid,
  output logic [ODATA_BIT-1:0] odata,
  output logic [PACK_NUM-1:0]  odata_mask,
  output logic                 odata_last,
  output logic                 odata_valid,
  input  logic                 odata_ready,
  output logic                 overflow
`ifdef CONSMAX_PACK_SUM_EN
  ,
  output logic signed [IDATA_BIT+ROW_BIT-1:0] odata_sum
`endif
);
  import consmax_pkg::*;
  localparam int LANE_BIT = $clog2(PACK_NUM);
  localparam int SBIT = IDATA_BIT + ROW_BIT;
  logic [LANE_BIT-1:0] lane_q, lane_d;
  logic [ROW_BIT-1:0] elem_q, elem_d, len_q, len_d, cur_len;
  logic [ODATA_BIT-1:0] asm_q, asm_d, asm_w;
  logic [PACK_NUM-1:0] mask_q, mask_d, mask_w;
  logic ovf_q, ovf_d;
  logic first, row_end, word_done, pop, full, empty, drop;
  entry_t push_e, head_e;
`ifdef CONSMAX_PACK_SUM_EN
  logic signed [SBIT-1:0] acc_q, acc_d, acc_w;
  assign acc_w = acc_q + SBIT'($signed(idata));
  assign acc_d = !idata_valid ? acc_q : row_end ? '0 : acc_w;
  assign odata_sum = head_e.sum;
`endif
  always_comb begin
    asm_w = asm_q;
    asm_w[lane_q*IDATA_BIT +: IDATA_BIT] = idata;
  end
  assign mask_w = mask_q | (PACK_NUM'(1) << lane_q);
  // The first element of a row sees cfg_row_len directly; later ones use the latched length.
  assign first = elem_q == '0;
  assign cur_len = first ? cfg_row_len : len_q;
  assign row_end = elem_q == (cur_len == '0 ? '0 : cur_len - ROW_BIT'(1));
  assign word_done = idata_valid && (lane_q == LANE_BIT'(PACK_NUM - 1) || row_end);
  assign lane_d = !idata_valid ? lane_q : word_done ? '0 : lane_q + LANE_BIT'(1);
  assign elem_d = !idata_valid ? elem_q : row_end ? '0 : elem_q + ROW_BIT'(1);
  assign len_d = idata_valid && first ? cfg_row_len : len_q;
  assign asm_d = !idata_valid ? asm_q : word_done ? '0 : asm_w;
  assign mask_d = !idata_valid ? mask_q : word_done ? '0 : mask_w;
  assign pop = !empty && odata_ready;
  // A completed word is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop = word_done && full && !pop;
  assign ovf_d = drop | (ovf_q & ~clr_overflow);
  always_comb begin
    push_e = '0;
    push_e.data = asm_w;
    push_e.mask = mask_w;
    push_e.last = row_end;
`ifdef CONSMAX_PACK_SUM_EN
    push_e.sum = row_end ? acc_w : '0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      elem_q <= '0;
      len_q <= '0;
      asm_q <= '0;
      mask_q <= '0;
      ovf_q <= 1'b0;
`ifdef CONSMAX_PACK_SUM_EN
      acc_q <= '0;
`endif
    end else begin
      lane_q <= lane_d;
      elem_q <= elem_d;
      len_q <= len_d;
      asm_q <= asm_d;
      mask_q <= mask_d;
      ovf_q <= ovf_d;
`ifdef CONSMAX_PACK_SUM_EN
      acc_q <= acc_d;
`endif
    end
  end
  consmax_pack_fifo #(.DW($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(word_done),
    .push_data_i(push_e),
    .pop_i(pop),
    .data_o(head_e),
    .full_o(full),
    .empty_o(empty)
  );
  assign odata = head_e.data;
  assign odata_mask = head_e.mask;
  assign odata_last = head_e.last;
  assign odata_valid = !empty;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_consmax_pack.sv
// tb_consmax_pack: randomized and directed checks of consmax_pack against a queue-based row/word model.
module tb_consmax_pack;
`ifdef CONSMAX_PACK_SUM_EN
  localparam int OW = 75 + 18;
`else
  localparam int OW = 75;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [9:0] cfg_row_len;
  logic clr_overflow;
  logic [7:0] idata;
  logic idata_valid;
  logic [63:0] odata;
  logic [7:0] odata_mask;
  logic odata_last, odata_valid, odata_ready, overflow;
`ifdef CONSMAX_PACK_SUM_EN
  logic signed [17:0] odata_sum;
`endif
  int checks = 0;
  int fails = 0;
  typedef struct {
    logic [63:0] data;
    logic [7:0] mask;
    logic last;
    logic [17:0] sum;
  } w_t;
  w_t q[$];
  logic [7:0] cur[$];
  int pos = 0;
  int rowlen = 1;
  int rsum = 0;
  logic ovf = 1'b0;
  consmax_pack dut (
    .clk(clk),
    .rst(rst),
    .cfg_row_len(cfg_row_len),
    .clr_overflow(clr_overflow),
    .idata(idata),
    .idata_valid(idata_valid),
    .odata(odata),
    .odata_mask(odata_mask),
    .odata_last(odata_last),
    .odata_valid(odata_valid),
    .odata_ready(odata_ready),
    .overflow(overflow)
`ifdef CONSMAX_PACK_SUM_EN
    ,
    .odata_sum(odata_sum)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [OW-1:0] obs();
    logic [OW-1:0] r;
    r = '0;
    r[OW-1] = odata_valid;
    r[OW-2] = overflow;
    if (odata_valid) begin
      r[OW-3] = odata_last;
      r[OW-4 -: 8] = odata_mask;
      r[OW-12 -: 64] = odata;
`ifdef CONSMAX_PACK_SUM_EN
      r[17:0] = odata_sum;
`endif
    end
    return r;
  endfunction
  function automatic logic [OW-1:0] exp_out();
    logic [OW-1:0] r;
    r = '0;
    r[OW-1] = q.size() != 0;
    r[OW-2] = ovf;
    if (q.size() != 0) begin
      r[OW-3] = q[0].last;
      r[OW-4 -: 8] = q[0].mask;
      r[OW-12 -: 64] = q[0].data;
`ifdef CONSMAX_PACK_SUM_EN
      r[17:0] = q[0].sum;
`endif
    end
    return r;
  endfunction
  task automatic model_reset();
    q.delete();
    cur.delete();
    pos = 0;
    rsum = 0;
    ovf = 1'b0;
  endtask
  // Drive one cycle from a negedge to the next and advance the model by the same cycle.
  task automatic drive(input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    w_t w;
    logic pop, done, acc;
    int n;
    idata_valid = v;
    idata = d;
    odata_ready = rdy;
    clr_overflow = clr;
    pop = (q.size() != 0) && rdy;
    done = 1'b0;
    w = '{default: 0};
    if (v) begin
      if (pos == 0) rowlen = (cfg_row_len == 0) ? 1 : int'(cfg_row_len);
      cur.push_back(d);
      pos++;
      rsum += int'($signed(d));
      if (cur.size() == 8 || pos == rowlen) begin
        done = 1'b1;
        n = cur.size();
        foreach (cur[k]) w.data[k*8 +: 8] = cur[k];
        w.mask = 8'((1 << n) - 1);
        w.last = pos == rowlen;
        w.sum = w.last ? 18'(rsum) : 18'd0;
        if (w.last) begin
          pos = 0;
          rsum = 0;
        end
        cur.delete();
      end
    end
    acc = done && (q.size() < 4 || pop);
    if (done && !acc) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(w);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cfg_row_len = 10'd8;
    clr_overflow = 1'b0;
    idata = '0;
    idata_valid = 1'b0;
    odata_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({odata, odata_mask, odata_last, odata_valid, overflow} !== '0) begin
      fails++;
      $display("FAIL reset outputs: got %h/%h/%b/%b/%b, expected all zero", odata, odata_mask, odata_last, odata_valid, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_row16();
    cfg_row_len = 10'd16;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL row16 elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
      if (i == 7) begin
        checks++;
        if (odata_valid !== 1'b0) begin
          fails++;
          $display("FAIL row16 early valid: got %b, expected 0", odata_valid);
        end
      end
      if (i == 8) begin
        checks++;
        if ({odata_valid, odata, odata_mask, odata_last} !== {1'b1, 64'h0807060504030201, 8'hFF, 1'b0}) begin
          fails++;
          $display("FAIL row16 word1: got %b %h %h %b, expected 1 0807060504030201 ff 0", odata_valid, odata, odata_mask, odata_last);
        end
      end
      if (i == 16) begin
        checks++;
        if ({odata_valid, odata, odata_mask, odata_last} !== {1'b1, 64'h100F0E0D0C0B0A09, 8'hFF, 1'b1}) begin
          fails++;
          $display("FAIL row16 word2: got %b %h %h %b, expected 1 100f0e0d0c0b0a09 ff 1", odata_valid, odata, odata_mask, odata_last);
        end
      end
    end
    repeat (3) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL row16 drain: got %h, expected %h", obs(), exp_out());
      end
    end
  endtask
  task automatic test_row11();
    cfg_row_len = 10'd11;
    for (int i = 1; i <= 11; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL row11 elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if ({odata, odata_mask, odata_last} !== {64'h00000000000B0A09, 8'h07, 1'b1}) begin
      fails++;
      $display("FAIL row11 padded word: got %h %h %b, expected 0b0a09 07 1", odata, odata_mask, odata_last);
    end
    cfg_row_len = 10'd8;
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 8'(8'h30 + i), 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL row11 next row step %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
  endtask
  task automatic test_overflow();
    cfg_row_len = 10'd48;
    for (int i = 1; i <= 48; i++) begin
      drive(1'b1, 8'(i), 1'b0, i == 48);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL overflow elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
      if (i == 40 || i == 48) begin
        checks++;
        if (overflow !== 1'b1) begin
          fails++;
          $display("FAIL overflow flag at elem %0d: got %b, expected 1", i, overflow);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1, i == 5);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL overflow drain %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow clear: got %b, expected 0", overflow);
    end
    cfg_row_len = 10'd8;
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, 8'(8'hC0 + i), 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL overflow realign %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
  endtask
  task automatic test_full_pushpop();
    cfg_row_len = 10'd40;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 8'(8'h40 + i), i == 40, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL full_pushpop elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_pushpop overflow: got %b, expected 0", overflow);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL full_pushpop drain %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
  endtask
  task automatic test_reset_mid_row();
    cfg_row_len = 10'd12;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h90 + i), 1'b1, 1'b0);
    idata_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({odata, odata_mask, odata_last, odata_valid, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs: got %h/%h/%b/%b/%b, expected all zero", odata, odata_mask, odata_last, odata_valid, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    cfg_row_len = 10'd8;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL reset_mid elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if ({odata, odata_mask, odata_last} !== {64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b1}) begin
      fails++;
      $display("FAIL reset_mid fresh word: got %h %h %b, expected a7a6a5a4a3a2a1a0 ff 1", odata, odata_mask, odata_last);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_sum();
    logic [7:0] v[4];
    v = '{8'h7F, 8'h80, 8'h05, 8'hFF};
    cfg_row_len = 10'd4;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, v[i], 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL sum elem %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if ({odata, odata_mask, odata_last} !== {64'h00000000FF05807F, 8'h0F, 1'b1}) begin
      fails++;
      $display("FAIL sum word: got %h %h %b, expected ff05807f 0f 1", odata, odata_mask, odata_last);
    end
`ifdef CONSMAX_PACK_SUM_EN
    checks++;
    if (odata_sum !== 18'sd3) begin
      fails++;
      $display("FAIL sum value: got %0d, expected 3", odata_sum);
    end
`endif
    drive(1'b0, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_random();
    int rp;
    rp = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: rp = 0;
          1: rp = 10;
          2: rp = 50;
          default: rp = 100;
        endcase
      end
      if ($urandom_range(0, 15) == 0) cfg_row_len = 10'($urandom_range(0, 20));
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < rp, $urandom_range(0, 31) == 0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL random cycle %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        fails++;
        $display("FAIL random drain %0d: got %h, expected %h", i, obs(), exp_out());
      end
    end
  endtask
  initial begin
    test_reset();
    test_row16();
    test_row11();
    test_overflow();
    test_full_pushpop();
    test_reset_mid_row();
    test_sum();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
